// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parametrised register file: two write ports (B has priority over A on an
//   address collision), two combinational read ports, optional hardwired-zero
//   entry 0, and a background clear sweep that zeroes one entry per cycle.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   ZERO_REG  1 = entry 0 reads 0 and ignores writes
//
// Ports
//   clk                      clock, rising edge
//   clr                      asynchronous active-low reset
//   wr_en_a/addr_a/data_a    write port A
//   wr_en_b/addr_b/data_b    write port B (wins over A on same address)
//   rd_addr_a / rd_data_a    read port A (combinational)
//   rd_addr_b / rd_data_b    read port B (combinational)
//   sweep_req                level request, sampled while idle
//   sweep_busy               clear sweep in progress
//   sweep_done               one-cycle pulse after the last entry is cleared
//
// Build option
//   REGFILE_BYPASS_EN        forward accepted same-cycle writes to the reads
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              sweep_req,
    output logic              sweep_busy,
    output logic              sweep_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_done;
    logic              w_done_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_we_a;
    logic              w_we_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_busy = (r_state == CLEAR);

    // A write is accepted only while idle and, with ZERO_REG, never to entry 0.
    // The same qualified enables drive both storage and forwarding.
    assign w_we_a = wr_en_a && !w_busy && !((ZERO_REG != 0) && (wr_addr_a == '0));
    assign w_we_b = wr_en_b && !w_busy && !((ZERO_REG != 0) && (wr_addr_b == '0));

    // ---------------- sweep FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (sweep_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (r_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            // Index wraps to 0 naturally after the last entry.
            if (w_busy) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_busy) begin
                    if (r_idx == ADDR_W'(i)) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_we_b && (wr_addr_b == ADDR_W'(i))) begin
                    r_mem[i] <= wr_data_b;
                end else if (w_we_a && (wr_addr_a == ADDR_W'(i))) begin
                    r_mem[i] <= wr_data_a;
                end
            end
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        w_rd_a = r_mem[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (w_we_b && (wr_addr_b == rd_addr_a)) begin
            w_rd_a = wr_data_b;
        end else if (w_we_a && (wr_addr_a == rd_addr_a)) begin
            w_rd_a = wr_data_a;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            w_rd_a = '0;
        end
    end

    always_comb begin
        w_rd_b = r_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_we_b && (wr_addr_b == rd_addr_b)) begin
            w_rd_b = wr_data_b;
        end else if (w_we_a && (wr_addr_a == rd_addr_b)) begin
            w_rd_b = wr_data_a;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            w_rd_b = '0;
        end
    end

    assign rd_data_a  = w_rd_a;
    assign rd_data_b  = w_rd_b;
    assign sweep_busy = w_busy;
    assign sweep_done = r_done;

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Scoreboard bench. Stimulus is driven 1 time unit after each rising edge
//   and the expected outputs for that cycle are queued; a monitor pops one
//   entry on every falling edge and compares. Two instances share the inputs:
//   u_dut (ZERO_REG=0) and u_z (ZERO_REG=1, read port A checked).
// ---------------------------------------------------------------------------
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en_a = 1'b0;
    logic [2:0]  wr_addr_a = '0;
    logic [15:0] wr_data_a = '0;
    logic        wr_en_b = 1'b0;
    logic [2:0]  wr_addr_b = '0;
    logic [15:0] wr_data_b = '0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;
    logic        sweep_req = 1'b0;
    logic [15:0] rd_data_a, rd_data_b, z_rd_a, z_rd_b;
    logic        sweep_busy, sweep_done, z_busy, z_done;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut (
        .clk(clk), .clr(clr),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .sweep_req(sweep_req), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_z (
        .clk(clk), .clr(clr),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_b),
        .sweep_req(sweep_req), .sweep_busy(z_busy), .sweep_done(z_done)
    );

    typedef struct packed {
        logic [15:0] ra;
        logic [15:0] rb;
        logic        busy;
        logic        done;
        logic [15:0] za;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_err = 0;
    int    n_chk = 0;
    exp_t  m_e;
    string m_n;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] ra, input logic [15:0] rb,
                        input logic busy, input logic done, input logic [15:0] za);
        exp_t e;
        e.ra = ra; e.rb = rb; e.busy = busy; e.done = done; e.za = za;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (q_exp.size() != 0) begin
            m_e = q_exp.pop_front();
            m_n = q_name.pop_front();
            chk({m_n, ".rd_a"}, rd_data_a, m_e.ra);
            chk({m_n, ".rd_b"}, rd_data_b, m_e.rb);
            chk({m_n, ".busy"}, {15'd0, sweep_busy}, {15'd0, m_e.busy});
            chk({m_n, ".done"}, {15'd0, sweep_done}, {15'd0, m_e.done});
            chk({m_n, ".z_rd_a"}, z_rd_a, m_e.za);
            chk({m_n, ".z_busy"}, {15'd0, z_busy}, {15'd0, m_e.busy});
        end
    end

    initial begin
        step();
        step();
        // reset state
        rd_addr_a = 3; rd_addr_b = 4;
        push("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step();

        // single write A, addr 3
        clr = 1'b1;
        wr_en_a = 1'b1; wr_addr_a = 3; wr_data_a = 16'h1234;
        push("wrA_same", BYP ? 16'h1234 : 16'h0000, 16'h0000, 1'b0, 1'b0,
             BYP ? 16'h1234 : 16'h0000);
        step();
        wr_en_a = 1'b0;
        push("wrA_next", 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234);
        step();

        // collision on addr 5: B wins
        wr_en_a = 1'b1; wr_addr_a = 5; wr_data_a = 16'hAAAA;
        wr_en_b = 1'b1; wr_addr_b = 5; wr_data_b = 16'h5555;
        rd_addr_a = 5; rd_addr_b = 3;
        push("coll_same", BYP ? 16'h5555 : 16'h0000, 16'h1234, 1'b0, 1'b0,
             BYP ? 16'h5555 : 16'h0000);
        step();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        push("coll_next", 16'h5555, 16'h1234, 1'b0, 1'b0, 16'h5555);
        step();

        // independent writes to different addresses
        wr_en_a = 1'b1; wr_addr_a = 1; wr_data_a = 16'h1111;
        wr_en_b = 1'b1; wr_addr_b = 2; wr_data_b = 16'h2222;
        rd_addr_a = 1; rd_addr_b = 2;
        push("indep_same", BYP ? 16'h1111 : 16'h0000, BYP ? 16'h2222 : 16'h0000,
             1'b0, 1'b0, BYP ? 16'h1111 : 16'h0000);
        step();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        push("indep_next", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h1111);
        step();

        // write to addr 0: kept by u_dut, dropped by u_z
        wr_en_a = 1'b1; wr_addr_a = 0; wr_data_a = 16'hFFFF;
        rd_addr_a = 0; rd_addr_b = 0;
        push("zero_same", BYP ? 16'hFFFF : 16'h0000, BYP ? 16'hFFFF : 16'h0000,
             1'b0, 1'b0, 16'h0000);
        step();
        wr_en_a = 1'b0;
        push("zero_next", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
        step();

        // load entry k with 0x00k1
        for (int k = 0; k < 8; k++) begin
            wr_en_a = 1'b1; wr_addr_a = 3'(k); wr_data_a = 16'(16 * k + 1);
            step();
        end
        wr_en_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rd_addr_a = 3'(2 * j); rd_addr_b = 3'(2 * j + 1);
            push($sformatf("load_rd%0d", j), 16'(32 * j + 1), 16'(32 * j + 17),
                 1'b0, 1'b0, (j == 0) ? 16'h0000 : 16'(32 * j + 1));
            step();
        end

        // sweep: req sampled at edge 0, busy cycles 1..8, done in cycle 9
        sweep_req = 1'b1; rd_addr_a = 2; rd_addr_b = 7;
        push("sweep_c0", 16'h0021, 16'h0071, 1'b0, 1'b0, 16'h0021);
        step();
        for (int c = 1; c <= 8; c++) begin
            sweep_req = 1'b0;
            wr_en_a = (c == 5); wr_addr_a = 2; wr_data_a = 16'hBEEF;
            push($sformatf("sweep_c%0d", c), (c >= 4) ? 16'h0000 : 16'h0021, 16'h0071,
                 1'b1, 1'b0, (c >= 4) ? 16'h0000 : 16'h0021);
            step();
        end
        wr_en_a = 1'b0;
        push("sweep_c9", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
        step();
        for (int j = 0; j < 4; j++) begin
            rd_addr_a = 3'(2 * j); rd_addr_b = 3'(2 * j + 1);
            push($sformatf("swept_rd%0d", j), 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
            step();
        end

        // reset in cycle 4 of a sweep
        wr_en_a = 1'b1; wr_addr_a = 6; wr_data_a = 16'h0606;
        wr_en_b = 1'b1; wr_addr_b = 7; wr_data_b = 16'h0707;
        step();
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        rd_addr_a = 6; rd_addr_b = 7;
        sweep_req = 1'b1;
        step();
        sweep_req = 1'b0;
        step();
        step();
        push("rst_c3", 16'h0606, 16'h0707, 1'b1, 1'b0, 16'h0606);
        step();
        clr = 1'b0;
        push("rst_c4", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step();
        clr = 1'b1;
        for (int c = 5; c <= 12; c++) begin
            push($sformatf("rst_c%0d", c), 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
            step();
        end
        wr_en_a = 1'b1; wr_addr_a = 7; wr_data_a = 16'h0042;
        rd_addr_a = 7;
        push("post_rst_same", BYP ? 16'h0042 : 16'h0000, BYP ? 16'h0042 : 16'h0000,
             1'b0, 1'b0, BYP ? 16'h0042 : 16'h0000);
        step();
        wr_en_a = 1'b0;
        push("post_rst_next", 16'h0042, 16'h0042, 1'b0, 1'b0, 16'h0042);
        step();

        // forwarding from port B
        wr_en_b = 1'b1; wr_addr_b = 6; wr_data_b = 16'h0F0F;
        rd_addr_a = 6; rd_addr_b = 7;
        push("byp_same", BYP ? 16'h0F0F : 16'h0000, 16'h0042, 1'b0, 1'b0,
             BYP ? 16'h0F0F : 16'h0000);
        step();
        wr_en_b = 1'b0;
        push("byp_next", 16'h0F0F, 16'h0042, 1'b0, 1'b0, 16'h0F0F);
        step();

        // sweep_req held high across sweep_done restarts immediately
        sweep_req = 1'b1;
        push("hold_c0", 16'h0F0F, 16'h0042, 1'b0, 1'b0, 16'h0F0F);
        step();
        for (int c = 1; c <= 7; c++) step();
        push("hold_c8", 16'h0000, 16'h0042, 1'b1, 1'b0, 16'h0000);
        step();
        push("hold_c9", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
        step();
        push("hold_c10", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        step();
        sweep_req = 1'b0;
        for (int c = 11; c <= 17; c++) step();
        push("hold_c18", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
        step();
        push("hold_c19", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        step();

        n_chk++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-port register file, the successor to the fixed 8×16 single-write file in the single-cycle datapath. It has configurable width and depth and two write ports with defined collision priority. An optional hardwired-zero register 0 is available, along with a background clear sweep sequencer that zeroes the file one entry per cycle. It sits between the decode stage (read addresses) and the writeback stage (ALU result and load data on separate write ports).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes and sweep

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  asynchronous, active-low reset
- wr_en_a  in  1  write enable, port A
- wr_addr_a  in  ADDR_W  write address, port A
- wr_data_a  in  DATA_W  write data, port A
- wr_en_b  in  1  write enable, port B (priority over A)
- wr_addr_b  in  ADDR_W  write address, port B
- wr_data_b  in  DATA_W  write data, port B
- rd_addr_a  in  ADDR_W  read address, read port A
- rd_data_a  out  DATA_W  read data, read port A (combinational)
- rd_addr_b  in  ADDR_W  read address, read port B
- rd_data_b  out  DATA_W  read data, read port B (combinational)
- sweep_req  in  1  request clear sweep (level, sampled in IDLE)
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after last entry is cleared

## Operation
- Reset (clr=0): all entries 0, state IDLE, sweep index 0, sweep_busy=0, sweep_done=0. Read outputs therefore show 0.
- Writes: at a rising edge, each enabled port writes its data to its address.
  - If both ports are enabled to the same address, port B's data wins.
  - Different addresses write independently.
- ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0.
- Reads: rd_data_x = entry[rd_addr_x], purely combinational.
- Sweep FSM, states IDLE and CLEAR:
  - IDLE: if sweep_req=1 at an edge → CLEAR, with index=0.
  - CLEAR: at each edge, entry[index] ← 0 and index increments. At the edge where index = DEPTH-1, go to IDLE and assert sweep_done for the following cycle.
  - sweep_busy = (state == CLEAR).
- During CLEAR, both write ports are ignored entirely, and sweep_req is ignored.
- Reset mid-sweep: the file is immediately zero, state is IDLE, and no sweep_done pulse is produced.
- A sweep_req still high after sweep_done starts a new sweep at the next edge.

## Timing
- Write-to-read latency is 1 cycle: data written at edge N is visible on read ports during cycle N+1 (without bypass).
- Sweep with DEPTH=8: req sampled at edge 0; sweep_busy high in cycles 1–8; entry k is cleared at edge k+1; sweep_done high in cycle 9; writes accepted again from edge 9.
- Sweep length is always DEPTH cycles. Entry 0 is still visited under ZERO_REG, with no effect.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding.
  - If an accepted write in the current cycle targets rd_addr_x, rd_data_x returns that write data combinationally in the same cycle.
  - Port B takes priority over port A when both target rd_addr_x.
  - No forwarding while sweep_busy=1.
  - No forwarding for address 0 when ZERO_REG=1.
- Undefined: reads return stored contents only; 1-cycle write-to-read latency.

## Test plan
- Reset, then write A: addr 3 = 0x1234. Cycle after the edge, rd_addr_a=3 → 0x1234, and rd_addr_b=4 → 0x0000.
- Collision: A and B both write addr 5, with A=0xAAAA and B=0x5555. Next cycle, read addr 5 → 0x5555.
- ZERO_REG=1: write addr 0 = 0xFFFF. Read addr 0 → 0x0000. With REGFILE_BYPASS_EN defined, the same-cycle read of addr 0 is also 0x0000.
- Sweep:
  - Load all 8 entries with 0x00k1, then pulse sweep_req. sweep_busy stays high exactly 8 cycles and sweep_done pulses once.
  - A write of 0xBEEF to addr 2 issued during busy is dropped.
  - All entries read 0 afterward.
- Reset mid-sweep: assert clr in cycle 4 of a sweep. All entries → 0, sweep_busy→0, no sweep_done. A later write of 0x0042 to addr 7 is read back correctly.
- REGFILE_BYPASS_EN defined: write B addr 6 = 0x0F0F with rd_addr_a=6 in the same cycle → rd_data_a=0x0F0F before the edge. Undefined: old value before the edge, 0x0F0F after.
